sbuf_pingpong_ctrl: RTL and testbench

Double-buffer (ping-pong) controller for the systolic array's operand buffers. It owns two 128x16 1R1W buffer banks. A producer stream fills one bank while the other bank is replayed to the array edge a configurable number of times, which supports weight/operand reuse. It sits between the host/DMA load path and the array input skew stage.

---
 rtl/sbuf_pingpong_ctrl_pkg.sv | 24 ++
 rtl/sbuf_bank_state.sv | 57 +++++
 rtl/sbuf_ram.sv | 32 +++
 rtl/sbuf_pingpong_ctrl.sv | 170 +++++++++++++++++
 tb/tb_sbuf_pingpong_ctrl.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/sbuf_pingpong_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sbuf_pingpong_ctrl_pkg
// Purpose  : Shared encodings and default widths for the ping-pong buffer.
// Revision : 1.0 - initial release
// ============================================================================
package sbuf_pingpong_ctrl_pkg;

    localparam int c_def_dw = 16;
    localparam int c_def_aw = 7;
    localparam int c_def_rw = 4;

    typedef logic [1:0] bank_state_t;
    localparam bank_state_t c_bank_empty    = 2'd0;
    localparam bank_state_t c_bank_filling  = 2'd1;
    localparam bank_state_t c_bank_full     = 2'd2;
    localparam bank_state_t c_bank_draining = 2'd3;

    typedef logic [0:0] rd_state_t;
    localparam rd_state_t c_rd_idle = 1'b0;
    localparam rd_state_t c_rd_run  = 1'b1;

endpackage
`default_nettype wire

// File: rtl/sbuf_bank_state.sv
`default_nettype none
// ============================================================================
// Module   : sbuf_bank_state
// Purpose  : Per-bank EMPTY/FILLING/FULL/DRAINING tracker with length latch.
// Revision : 1.0 - initial release
// ============================================================================
module sbuf_bank_state
    import sbuf_pingpong_ctrl_pkg::*;
#(
    parameter int AW = 7
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_wr_accept,
    input  logic [AW-1:0] i_wr_ptr,
    input  logic [AW-1:0] i_cfg_last,
    input  logic          i_claim,
    input  logic          i_release,
    output bank_state_t   o_state,
    output logic [AW-1:0] o_len,
    output logic          o_wr_last
);

    bank_state_t   r_state;
    logic [AW-1:0] r_len;
    logic [AW-1:0] w_len_eff;
    logic          w_wr_last;

    // The first write still sees the live cfg_last, before it has been latched.
    assign w_len_eff = (r_state == c_bank_empty) ? i_cfg_last : r_len;
    assign w_wr_last = i_wr_accept && (i_wr_ptr == w_len_eff);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_bank_empty;
            r_len   <= '0;
        end else begin
            case (r_state)
                c_bank_empty: begin
                    if (i_wr_accept) begin
                        r_len   <= i_cfg_last;
                        r_state <= w_wr_last ? c_bank_full : c_bank_filling;
                    end
                end
                c_bank_filling: if (w_wr_last) r_state <= c_bank_full;
                c_bank_full:    if (i_claim)   r_state <= c_bank_draining;
                default:        if (i_release) r_state <= c_bank_empty;
            endcase
        end
    end

    assign o_state   = r_state;
    assign o_len     = r_len;
    assign o_wr_last = w_wr_last;

endmodule
`default_nettype wire

// File: rtl/sbuf_ram.sv
`default_nettype none
// ============================================================================
// Module   : sbuf_ram
// Purpose  : 1R1W buffer RAM with a registered read port (1-cycle latency).
// Revision : 1.0 - initial release
// ============================================================================
module sbuf_ram #(
    parameter int DW = 16,
    parameter int AW = 7
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] r_mem [2**AW];
    logic [DW-1:0] r_rdata;

    // Read data only advances when re is high, so a stalled reader keeps its word.
    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
        if (i_re) r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/sbuf_pingpong_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sbuf_pingpong_ctrl
// Purpose  : Ping-pong operand buffer: fill one bank while replaying the other.
// Revision : 1.0 - initial release
// ============================================================================
module sbuf_pingpong_ctrl
    import sbuf_pingpong_ctrl_pkg::*;
#(
    parameter int DW = c_def_dw,
    parameter int AW = c_def_aw,
    parameter int RW = c_def_rw
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] cfg_last,
    input  logic [RW-1:0] cfg_repeat,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [DW-1:0] wr_data,
    output logic          rd_valid,
    input  logic          rd_ready,
    output logic [DW-1:0] rd_data,
    output logic          rd_last,
    output logic [1:0]    bank_full,
    output logic          busy
);

    logic          r_wr_bank;
    logic [AW-1:0] r_wr_ptr;
    logic          r_rd_bank;
    rd_state_t     r_rd_state;
    logic [AW-1:0] r_rd_ptr;
    logic [RW-1:0] r_rep_cnt;
    logic          r_rd_valid;

    bank_state_t   w_bank_state   [2];
    logic [AW-1:0] w_bank_len     [2];
    logic          w_bank_wr_last [2];
    logic [DW-1:0] w_ram_q        [2];

    logic          w_wr_ready;
    logic          w_wr_accept;
    logic          w_wr_last;
    logic [AW-1:0] w_rd_len;
    logic          w_rd_accept;
    logic          w_rd_en;
    logic [AW-1:0] w_rd_addr;
    logic          w_claim;
    logic          w_release;

    assign w_wr_ready  = (w_bank_state[r_wr_bank] == c_bank_empty) ||
                         (w_bank_state[r_wr_bank] == c_bank_filling);
    assign w_wr_accept = wr_valid && w_wr_ready;
    assign w_wr_last   = w_bank_wr_last[r_wr_bank];
    assign w_rd_len    = w_bank_len[r_rd_bank];
    assign w_rd_accept = r_rd_valid && rd_ready;

    // Address for the next word is issued in the accept cycle, so replays wrap without a bubble.
    always_comb begin
        w_rd_en   = 1'b0;
        w_rd_addr = r_rd_ptr;
        w_claim   = 1'b0;
        w_release = 1'b0;
        if (r_rd_state == c_rd_idle) begin
            if (w_bank_state[r_rd_bank] == c_bank_full) begin
                w_claim   = 1'b1;
                w_rd_en   = 1'b1;
                w_rd_addr = '0;
            end
        end else if (w_rd_accept) begin
            if (r_rd_ptr < w_rd_len) begin
                w_rd_en   = 1'b1;
                w_rd_addr = r_rd_ptr + 1'b1;
            end else if (r_rep_cnt != '0) begin
                w_rd_en   = 1'b1;
                w_rd_addr = '0;
            end else begin
                w_release = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_bank <= 1'b0;
            r_wr_ptr  <= '0;
        end else if (w_wr_accept) begin
            if (w_wr_last) begin
                r_wr_ptr  <= '0;
                r_wr_bank <= ~r_wr_bank;
            end else begin
                r_wr_ptr  <= r_wr_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_state <= c_rd_idle;
            r_rd_bank  <= 1'b0;
            r_rd_ptr   <= '0;
            r_rep_cnt  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            case (r_rd_state)
                c_rd_idle: begin
                    if (w_claim) begin
                        r_rd_state <= c_rd_run;
                        r_rep_cnt  <= cfg_repeat;
                        r_rd_ptr   <= '0;
                        r_rd_valid <= 1'b1;
                    end
                end
                default: begin
                    if (w_rd_accept) begin
                        if (r_rd_ptr < w_rd_len) begin
                            r_rd_ptr <= r_rd_ptr + 1'b1;
                        end else if (r_rep_cnt != '0) begin
                            r_rd_ptr  <= '0;
                            r_rep_cnt <= r_rep_cnt - 1'b1;
                        end else begin
                            r_rd_valid <= 1'b0;
                            r_rd_bank  <= ~r_rd_bank;
                            r_rd_state <= c_rd_idle;
                        end
                    end
                end
            endcase
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        localparam logic c_idx = 1'(b);

        sbuf_bank_state #(.AW(AW)) u_state (
            .clk         (clk),
            .rst_n       (rst_n),
            .i_wr_accept (w_wr_accept && (r_wr_bank == c_idx)),
            .i_wr_ptr    (r_wr_ptr),
            .i_cfg_last  (cfg_last),
            .i_claim     (w_claim && (r_rd_bank == c_idx)),
            .i_release   (w_release && (r_rd_bank == c_idx)),
            .o_state     (w_bank_state[b]),
            .o_len       (w_bank_len[b]),
            .o_wr_last   (w_bank_wr_last[b])
        );

        sbuf_ram #(.DW(DW), .AW(AW)) u_ram (
            .clk     (clk),
            .i_we    (w_wr_accept && (r_wr_bank == c_idx)),
            .i_waddr (r_wr_ptr),
            .i_wdata (wr_data),
            .i_re    (w_rd_en && (r_rd_bank == c_idx)),
            .i_raddr (w_rd_addr),
            .o_rdata (w_ram_q[b])
        );

        assign bank_full[b] = (w_bank_state[b] == c_bank_full) ||
                              (w_bank_state[b] == c_bank_draining);
    end

    assign wr_ready = w_wr_ready;
    assign rd_valid = r_rd_valid;
    assign rd_data  = w_ram_q[r_rd_bank];
    assign rd_last  = r_rd_valid && (r_rd_ptr == w_rd_len) && (r_rep_cnt == '0);
    assign busy     = (w_bank_state[0] != c_bank_empty) || (w_bank_state[1] != c_bank_empty);

endmodule
`default_nettype wire

// File: tb/tb_sbuf_pingpong_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sbuf_pingpong_ctrl
// Purpose  : Directed vector table plus stall, back-pressure and reset sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sbuf_pingpong_ctrl;

    logic        clk;
    logic        rst_n;
    logic [6:0]  cfg_last;
    logic [3:0]  cfg_repeat;
    logic        wr_valid;
    logic        wr_ready;
    logic [15:0] wr_data;
    logic        rd_valid;
    logic        rd_ready;
    logic [15:0] rd_data;
    logic        rd_last;
    logic [1:0]  bank_full;
    logic        busy;

    sbuf_pingpong_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_last   (cfg_last),
        .cfg_repeat (cfg_repeat),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_data    (wr_data),
        .rd_valid   (rd_valid),
        .rd_ready   (rd_ready),
        .rd_data    (rd_data),
        .rd_last    (rd_last),
        .bank_full  (bank_full),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Each record: inputs driven for one cycle, outputs expected during that cycle.
    typedef struct {
        logic        wv;
        logic [15:0] wd;
        logic [6:0]  cl;
        logic [3:0]  cr;
        logic        rr;
        logic        e_wr_ready;
        logic        e_rd_valid;
        logic [15:0] e_rd_data;
        logic        e_rd_last;
        logic [1:0]  e_bank_full;
        logic        e_busy;
    } vec_t;

    vec_t        vecs[$];
    logic [15:0] wq[$];
    logic [15:0] rq[$];
    logic        lq[$];
    int          n_checks = 0;
    int          n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic addv(input logic wv, input logic [15:0] wd, input logic [6:0] cl,
                        input logic [3:0] cr, input logic rr, input logic ewr,
                        input logic erv, input logic [15:0] erd, input logic erl,
                        input logic [1:0] ebf, input logic ebusy);
        vec_t v;
        v.wv = wv; v.wd = wd; v.cl = cl; v.cr = cr; v.rr = rr;
        v.e_wr_ready = ewr; v.e_rd_valid = erv; v.e_rd_data = erd;
        v.e_rd_last = erl; v.e_bank_full = ebf; v.e_busy = ebusy;
        vecs.push_back(v);
    endtask

    task automatic push_frame(input logic [15:0] base, input int n, input int reps);
        for (int r = 0; r < reps; r++) begin
            for (int k = 0; k < n; k++) begin
                rq.push_back(base + 16'(k));
                lq.push_back((r == reps - 1) && (k == n - 1));
            end
        end
        for (int k = 0; k < n; k++) wq.push_back(base + 16'(k));
    endtask

    // Writer and reader run together; optional 1,0,0,1 rd_ready pattern exercises stalls.
    task automatic run_stream(input int max_cycles, input bit use_stall);
        logic [15:0] held;
        bit          stalled;
        int          cyc;
        stalled = 1'b0;
        held    = '0;
        cyc     = 0;
        while ((wq.size() != 0 || rq.size() != 0) && cyc < max_cycles) begin
            @(negedge clk);
            rd_ready = use_stall ? ((cyc % 4) == 0 || (cyc % 4) == 3) : 1'b1;
            wr_valid = (wq.size() != 0);
            if (wq.size() != 0) wr_data = wq[0];
            if (stalled && rd_valid) chk("stall_hold", 32'(rd_data), 32'(held));
            if (wr_valid && wr_ready) void'(wq.pop_front());
            if (rd_valid && rd_ready) begin
                if (rq.size() == 0) begin
                    n_checks++;
                    $display("FAIL extra_word: got 0x%0h, expected no word", rd_data);
                end else begin
                    chk("stream_rd_data", 32'(rd_data), 32'(rq[0]));
                    chk("stream_rd_last", 32'(rd_last), 32'(lq[0]));
                    void'(rq.pop_front());
                    void'(lq.pop_front());
                end
            end
            stalled = rd_valid && !rd_ready;
            held    = rd_data;
            cyc++;
        end
        @(negedge clk);
        wr_valid = 1'b0;
        rd_ready = 1'b1;
        chk("stream_done", 32'(rq.size() + wq.size()), 32'd0);
    endtask

    initial begin
        int acc;
        rst_n = 1'b0; cfg_last = '0; cfg_repeat = '0;
        wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_wr_ready", 32'(wr_ready), 32'd1);
        chk("reset_rd_valid", 32'(rd_valid), 32'd0);
        chk("reset_rd_last", 32'(rd_last), 32'd0);
        chk("reset_bank_full", 32'(bank_full), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);

        // 4-word frame, single pass, into bank0
        addv(1, 16'h10, 3, 0, 1, 1, 0, 16'h0,  0, 2'b00, 0);
        addv(1, 16'h11, 3, 0, 1, 1, 0, 16'h0,  0, 2'b00, 1);
        addv(1, 16'h12, 3, 0, 1, 1, 0, 16'h0,  0, 2'b00, 1);
        addv(1, 16'h13, 3, 0, 1, 1, 0, 16'h0,  0, 2'b00, 1);
        addv(0, 16'h0,  3, 0, 1, 1, 0, 16'h0,  0, 2'b01, 1);
        addv(0, 16'h0,  3, 0, 1, 1, 1, 16'h10, 0, 2'b01, 1);
        addv(0, 16'h0,  3, 0, 1, 1, 1, 16'h11, 0, 2'b01, 1);
        addv(0, 16'h0,  3, 0, 1, 1, 1, 16'h12, 0, 2'b01, 1);
        addv(0, 16'h0,  3, 0, 1, 1, 1, 16'h13, 1, 2'b01, 1);
        addv(0, 16'h0,  3, 0, 1, 1, 0, 16'h0,  0, 2'b00, 0);
        // 2-word frame replayed 3 times from bank1
        addv(1, 16'hA,  1, 2, 1, 1, 0, 16'h0,  0, 2'b00, 0);
        addv(1, 16'hB,  1, 2, 1, 1, 0, 16'h0,  0, 2'b00, 1);
        addv(0, 16'h0,  1, 2, 1, 1, 0, 16'h0,  0, 2'b10, 1);
        addv(0, 16'h0,  1, 2, 1, 1, 1, 16'hA,  0, 2'b10, 1);
        addv(0, 16'h0,  1, 2, 1, 1, 1, 16'hB,  0, 2'b10, 1);
        addv(0, 16'h0,  1, 2, 1, 1, 1, 16'hA,  0, 2'b10, 1);
        addv(0, 16'h0,  1, 2, 1, 1, 1, 16'hB,  0, 2'b10, 1);
        addv(0, 16'h0,  1, 2, 1, 1, 1, 16'hA,  0, 2'b10, 1);
        addv(0, 16'h0,  1, 2, 1, 1, 1, 16'hB,  1, 2'b10, 1);
        addv(0, 16'h0,  1, 2, 1, 1, 0, 16'h0,  0, 2'b00, 0);
        // single-word frame back in bank0: valid two cycles after the write
        addv(1, 16'h55, 0, 0, 1, 1, 0, 16'h0,  0, 2'b00, 0);
        addv(0, 16'h0,  0, 0, 1, 1, 0, 16'h0,  0, 2'b01, 1);
        addv(0, 16'h0,  0, 0, 1, 1, 1, 16'h55, 1, 2'b01, 1);
        addv(0, 16'h0,  0, 0, 1, 1, 0, 16'h0,  0, 2'b00, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            wr_valid = vecs[i].wv; wr_data = vecs[i].wd;
            cfg_last = vecs[i].cl; cfg_repeat = vecs[i].cr; rd_ready = vecs[i].rr;
            chk($sformatf("vec%0d_wr_ready", i), 32'(wr_ready), 32'(vecs[i].e_wr_ready));
            chk($sformatf("vec%0d_rd_valid", i), 32'(rd_valid), 32'(vecs[i].e_rd_valid));
            chk($sformatf("vec%0d_bank_full", i), 32'(bank_full), 32'(vecs[i].e_bank_full));
            chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].e_busy));
            if (vecs[i].e_rd_valid) begin
                chk($sformatf("vec%0d_rd_data", i), 32'(rd_data), 32'(vecs[i].e_rd_data));
                chk($sformatf("vec%0d_rd_last", i), 32'(rd_last), 32'(vecs[i].e_rd_last));
            end
        end

        // Stalled drain: data held, nothing lost or duplicated
        cfg_last = 7'd3; cfg_repeat = 4'd0;
        push_frame(16'h20, 4, 1);
        run_stream(60, 1'b1);

        // Three frames with reader blocked: writer stops after two banks
        push_frame(16'h30, 4, 1);
        push_frame(16'h40, 4, 1);
        push_frame(16'h50, 4, 1);
        rd_ready = 1'b0;
        acc = 0;
        for (int c = 0; c < 20 && acc < 8; c++) begin
            @(negedge clk);
            wr_valid = 1'b1;
            wr_data  = wq[0];
            if (wr_ready) begin
                void'(wq.pop_front());
                acc++;
            end
        end
        @(negedge clk);
        chk("bp_accepted", 32'(acc), 32'd8);
        chk("bp_wr_ready", 32'(wr_ready), 32'd0);
        chk("bp_bank_full", 32'(bank_full), 32'b11);
        chk("bp_rd_valid", 32'(rd_valid), 32'd1);
        chk("bp_rd_data", 32'(rd_data), 32'h30);
        run_stream(100, 1'b0);

        // Reset in the middle of a drain
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            wr_valid = 1'b1;
            wr_data  = 16'h60 + 16'(k);
        end
        @(negedge clk);
        wr_valid = 1'b0;
        rd_ready = 1'b1;
        acc = 0;
        for (int c = 0; c < 20 && acc < 2; c++) begin
            @(negedge clk);
            if (rd_valid && rd_ready) acc++;
        end
        @(negedge clk);
        chk("mid_rst_accepted", 32'(acc), 32'd2);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_bank_full", 32'(bank_full), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_wr_ready", 32'(wr_ready), 32'd1);
        chk("post_rst_rd_valid", 32'(rd_valid), 32'd0);
        push_frame(16'h70, 4, 1);
        run_stream(40, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
